// File: rtl/smartpark_disp_pkg.sv
// Shared constants and types for the SmartPark 4-digit multiplexed display.
package smartpark_disp_pkg;

    // Default scan timing at 24 MHz: 1 ms per digit slot, 10 us blanked lead-in.
    localparam int unsigned SCAN_T_DEF = 24000;
    localparam int unsigned DEAD_T_DEF = 240;

    // Common-anode, active-low codes, bit order {dp,g,f,e,d,c,b,a}.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_D0 = 8'hC0;
    localparam logic [7:0] SEG_D1 = 8'hF9;
    localparam logic [7:0] SEG_D2 = 8'hA4;
    localparam logic [7:0] SEG_D3 = 8'hB0;
    localparam logic [7:0] SEG_D4 = 8'h99;
    localparam logic [7:0] SEG_D5 = 8'h92;
    localparam logic [7:0] SEG_D6 = 8'h82;
    localparam logic [7:0] SEG_D7 = 8'hF8;
    localparam logic [7:0] SEG_D8 = 8'h80;
    localparam logic [7:0] SEG_D9 = 8'h90;

    // Select lines are active-low; all high means no digit driven.
    localparam logic [3:0] SEL_NONE = 4'b1111;

    // Digit position currently being scanned; value equals the sel bit index.
    typedef enum logic [1:0] {
        DigUnits     = 2'd0,
        DigTens      = 2'd1,
        DigHundreds  = 2'd2,
        DigThousands = 2'd3
    } digit_e;

    // One frame's worth of BCD digits as captured at the frame boundary.
    typedef struct packed {
        logic [3:0] q;  // thousands
        logic [3:0] b;  // hundreds
        logic [3:0] s;  // tens
        logic [3:0] g;  // units
    } digits_t;

    // Active-low one-hot select for a digit position.
    function automatic logic [3:0] sel_for(digit_e d);
        logic [3:0] s;
        s = SEL_NONE;
        s[d] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// BCD to common-anode 7-segment decoder; non-BCD codes show a dash, dp always off.
module bcd7seg
    import smartpark_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [7:0] seg_o
);

    // Pure lookup; 10-15 fall through to the dash pattern.
    always_comb begin
        seg_o = SEG_DASH;
        unique case (bcd_i)
            4'd0:    seg_o = SEG_D0;
            4'd1:    seg_o = SEG_D1;
            4'd2:    seg_o = SEG_D2;
            4'd3:    seg_o = SEG_D3;
            4'd4:    seg_o = SEG_D4;
            4'd5:    seg_o = SEG_D5;
            4'd6:    seg_o = SEG_D6;
            4'd7:    seg_o = SEG_D7;
            4'd8:    seg_o = SEG_D8;
            4'd9:    seg_o = SEG_D9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan4.sv
// Four-digit multiplexed 7-segment scanner with frame-synchronous input
// shadowing, per-slot dead time and optional leading-zero blanking.
module seg_scan4
    import smartpark_disp_pkg::*;
#(
    parameter int unsigned SCAN_T = SCAN_T_DEF,
    parameter int unsigned DEAD_T = DEAD_T_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] s_g,
    input  logic [3:0] s_s,
    input  logic [3:0] s_b,
    input  logic [3:0] s_q,
    input  logic       lz_en,
    output logic [7:0] seg,
    output logic [3:0] sel
);

    localparam int unsigned CntW = (SCAN_T > 1) ? $clog2(SCAN_T) : 1;

    logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
    digit_e          idx_q, idx_d;
    digits_t         shadow_q, shadow_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      sel_q, sel_d;

    logic            slot_end;
    logic            frame_end;
    logic            in_dead;
    logic [3:0]      cur_digit;
    logic            cur_blank;
    logic [7:0]      cur_seg;
    logic            blank_q_dig;
    logic            blank_b_dig;
    logic            blank_s_dig;

    // Slot and frame boundary detection; compares done at 32 bits so odd
    // parameter values never truncate.
    always_comb begin
        slot_end  = (32'(slot_cnt_q) == (SCAN_T - 1));
        frame_end = slot_end && (idx_q == DigThousands);
        in_dead   = (32'(slot_cnt_q) < DEAD_T);
    end

    // Next-state for the slot counter, digit index and shadow registers.
    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        if (slot_end) begin
            slot_cnt_d = '0;
            idx_d      = digit_e'(idx_q + 2'd1);
        end
        // Snapshot only at the frame boundary so one frame never mixes samples.
        if (frame_end) begin
            shadow_d.g = s_g;
            shadow_d.s = s_s;
            shadow_d.b = s_b;
            shadow_d.q = s_q;
        end
    end

    // Leading-zero chain: each position blanks only if everything above it did.
    always_comb begin
        blank_q_dig = lz_en && (shadow_q.q == 4'd0);
        blank_b_dig = blank_q_dig && (shadow_q.b == 4'd0);
        blank_s_dig = blank_b_dig && (shadow_q.s == 4'd0);
    end

    // Pick the shadow digit and its blank flag for the slot being scanned.
    // Units never blank, so a zero reading still shows "0".
    always_comb begin
        cur_digit = shadow_q.g;
        cur_blank = 1'b0;
        unique case (idx_q)
            DigUnits: begin
                cur_digit = shadow_q.g;
                cur_blank = 1'b0;
            end
            DigTens: begin
                cur_digit = shadow_q.s;
                cur_blank = blank_s_dig;
            end
            DigHundreds: begin
                cur_digit = shadow_q.b;
                cur_blank = blank_b_dig;
            end
            DigThousands: begin
                cur_digit = shadow_q.q;
                cur_blank = blank_q_dig;
            end
            default: begin
                cur_digit = shadow_q.g;
                cur_blank = 1'b0;
            end
        endcase
    end

    bcd7seg u_dec (
        .bcd_i (cur_digit),
        .seg_o (cur_seg)
    );

    // Output next-state: dark during dead time; a blanked digit keeps its
    // select asserted so every slot has the same drive duty.
    always_comb begin
        seg_d = SEG_BLANK;
        sel_d = SEL_NONE;
        if (!in_dead) begin
            sel_d = sel_for(idx_q);
            seg_d = cur_blank ? SEG_BLANK : cur_seg;
        end
    end

    // State and output registers; reset darkens the display asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
            idx_q      <= DigUnits;
            shadow_q   <= '0;
            seg_q      <= SEG_BLANK;
            sel_q      <= SEL_NONE;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
        end
    end

    assign seg = seg_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_seg_scan4.sv
// Randomized self-checking bench for seg_scan4 against a frame-level model.
module tb_seg_scan4;

    localparam int unsigned S = 20;
    localparam int unsigned D = 4;
    localparam int unsigned F = 4 * S;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] s_g, s_s, s_b, s_q;
    logic       lz_en;
    logic [7:0] seg;
    logic [3:0] sel;

    int checks   = 0;
    int failures = 0;

    // Model state: cycles since reset release and the digits the current frame shows
    // (index 0 = units .. 3 = thousands).
    int unsigned k;
    logic [3:0]  sh [4];

    // Expected glyph per value: 0-9 standard common-anode, 10-15 a dash.
    logic [7:0] ref_pat [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

    seg_scan4 #(
        .SCAN_T (S),
        .DEAD_T (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_g   (s_g),
        .s_s   (s_s),
        .s_b   (s_b),
        .s_q   (s_q),
        .lz_en (lz_en),
        .seg   (seg),
        .sel   (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    task automatic set_inputs(input int q, input int b, input int s, input int g, input bit lz);
        s_q = 4'(q);
        s_b = 4'(b);
        s_s = 4'(s);
        s_g = 4'(g);
        lz_en = lz;
    endtask

    function automatic logic [3:0] rnd_digit();
        if ($urandom_range(0, 2) == 0) return 4'd0;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic rand_inputs();
        s_q = rnd_digit();
        s_b = rnd_digit();
        s_s = rnd_digit();
        s_g = rnd_digit();
        lz_en = 1'($urandom_range(0, 1));
    endtask

    // What the pins must show one clock after the model is at cycle k.
    task automatic model_expect(output logic [7:0] es, output logic [3:0] el);
        int unsigned slot;
        int unsigned d;
        bit          blank;
        slot = k % S;
        d    = (k / S) % 4;
        es   = 8'hFF;
        el   = 4'hF;
        if (slot >= D) begin
            el[d] = 1'b0;
            // A non-units digit is blanked when it and every digit above it are zero.
            blank = lz_en && (d != 0);
            for (int j = int'(d); j < 4; j++) begin
                if (sh[j] != 4'd0) blank = 1'b0;
            end
            es = blank ? 8'hFF : ref_pat[sh[d]];
        end
    endtask

    // One clock: entered and left at a negedge.
    task automatic step(input int unsigned chg_pct);
        logic [7:0] es;
        logic [3:0] el;
        if (chg_pct != 0 && $urandom_range(0, 99) < chg_pct) rand_inputs();
        model_expect(es, el);
        @(posedge clk);
        if (k % F == F - 1) begin
            sh[0] = s_g;
            sh[1] = s_s;
            sh[2] = s_b;
            sh[3] = s_q;
        end
        k++;
        @(negedge clk);
        chk("seg", seg, es);
        chk("sel", {4'h0, sel}, {4'h0, el});
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 4; i++) sh[i] = 4'd0;
    endtask

    // Reset asserted between clock edges must darken the pins immediately.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_seg", seg, 8'hFF);
        chk("arst_sel", {4'h0, sel}, 8'h0F);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold_seg", seg, 8'hFF);
        release_reset();
    endtask

    initial begin
        set_inputs(0, 0, 0, 0, 1'b0);
        k = 0;
        for (int i = 0; i < 4; i++) sh[i] = 4'd0;

        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_sel", {4'h0, sel}, 8'h0F);
        release_reset();

        // Scan order: first frame shows zeros, second shows 4 3 2 1 on q b s g.
        set_inputs(4, 3, 2, 1, 1'b0);
        repeat (2 * F) step(0);

        // Mid-frame change must not appear until the next frame boundary.
        repeat (30) step(0);
        set_inputs(9, 8, 7, 6, 1'b0);
        repeat (F - 30 + F) step(0);

        // Leading-zero blanking on 0050, then the same digits unblanked.
        set_inputs(0, 0, 5, 0, 1'b1);
        repeat (2 * F) step(0);
        lz_en = 1'b0;
        repeat (F) step(0);

        // All zero with blanking: units alone shows 0.
        set_inputs(0, 0, 0, 0, 1'b1);
        repeat (2 * F) step(0);

        // Invalid units code shows a dash.
        set_inputs(0, 0, 0, 12, 1'b1);
        repeat (2 * F) step(0);

        // Reset in the lit part of a slot with non-zero digits on display.
        set_inputs(4, 3, 2, 1, 1'b0);
        repeat (2 * F + 10) step(0);
        async_reset();
        repeat (3 * F) step(0);

        // Random inputs changing at arbitrary cycles.
        repeat (20 * F) step(6);
        repeat (S + 7) step(6);
        async_reset();
        repeat (4 * F) step(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
